// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add split into STAGES carry-chained chunks with valid/ready flow control.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int C = WIDTH / (STAGES < 1 ? 1 : STAGES);

  if (STAGES < 1 || WIDTH % (STAGES < 1 ? 1 : STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic w_rdy [STAGES+1];
  logic r_ovf;

  assign w_rdy[STAGES] = out_ready;
  assign in_ready      = w_rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : st
    // unsummed chunks k..STAGES-1 arrive aligned at bit 0
    localparam int UW = WIDTH - k * C;
    logic [UW-1:0]        w_a, w_b;
    logic                 w_v, w_ci, w_ld, r_vld, r_c;
    logic [C:0]           w_ch;
    logic [(k+1)*C-1:0]   w_s, r_s;
    if (k == 0) begin : g_in
      assign w_a  = a;
      assign w_b  = b;
      assign w_v  = in_valid;
      assign w_ci = cin;
      assign w_s  = w_ch[C-1:0];
    end else begin : g_in
      assign w_a  = st[k-1].g_up.r_a;
      assign w_b  = st[k-1].g_up.r_b;
      assign w_v  = st[k-1].r_vld;
      assign w_ci = st[k-1].r_c;
      assign w_s  = {w_ch[C-1:0], st[k-1].r_s};
    end
    assign w_ch     = {1'b0, w_a[C-1:0]} + {1'b0, w_b[C-1:0]} + {{C{1'b0}}, w_ci};
    assign w_rdy[k] = !r_vld || w_rdy[k+1];
    assign w_ld     = w_rdy[k] && w_v;
    always_ff @(posedge clk or negedge rst)
      if (!rst) r_vld <= 1'b0;
      else if (w_rdy[k]) r_vld <= w_v;
    // data only moves with a real operation so a drained output holds its last value
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_ld) begin
        r_c <= w_ch[C];
        r_s <= w_s;
      end
    if (k < STAGES - 1) begin : g_up
      logic [UW-C-1:0] r_a, r_b;
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld) begin
          r_a <= w_a[UW-1:C];
          r_b <= w_b[UW-1:C];
        end
    end
  end

  // carry into the MSB is a^b^sum at that bit; xor with carry out gives overflow
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ovf <= 1'b0;
    else if (st[STAGES-1].w_ld)
      r_ovf <= st[STAGES-1].w_a[C-1] ^ st[STAGES-1].w_b[C-1] ^ st[STAGES-1].w_ch[C-1] ^ st[STAGES-1].w_ch[C];

  assign out_valid = st[STAGES-1].r_vld;
  assign sum       = st[STAGES-1].r_s;
  assign cout      = st[STAGES-1].r_c;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: randomized and directed checks of several adder configurations against an arithmetic model.
module tb_pipelined_ripple_adder;
  localparam int CW [4] = '{8, 8, 8, 16};
  localparam int CS [4] = '{4, 1, 8, 2};

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   done [4];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = CW[g];
    localparam int S = CS[g];
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = ~MAXP;
    logic          rst_n, iv, in_ready, ordy, cin, ov, co, of;
    logic [W-1:0]  a, b, s;
    logic [W+1:0]  q [$];
    int unsigned   out_cyc [$];
    int unsigned   cyc = 0;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst_n), .in_valid(iv), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
      .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .ovf(of)
    );

    function automatic string tg(input string nm);
      return $sformatf("c%0d W%0d S%0d %s", g, W, S, nm);
    endfunction

    // {ovf, cout, sum} from integer arithmetic on unsigned and two's-complement values
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint m, ux, uy, tot, sx, sy, sg;
      logic   o;
      m   = longint'(1) << W;
      ux  = longint'(x);
      uy  = longint'(y);
      tot = ux + uy + longint'(c);
      sx  = x[W-1] ? ux - m : ux;
      sy  = y[W-1] ? uy - m : uy;
      sg  = sx + sy + longint'(c);
      o   = (sg >= m / 2) || (sg < -(m / 2));
      return {o, tot[W:0]};
    endfunction

    always @(negedge clk)
      if (rst_n) begin
        cyc++;
        if (iv && in_ready) q.push_back(model(a, b, cin));
        if (ov && ordy) begin
          chk(tg("pending"), 64'(q.size() != 0), 64'(1));
          if (q.size() != 0) chk(tg("result"), 64'({of, co, s}), 64'(q.pop_front()));
          out_cyc.push_back(cyc);
        end
      end

    task automatic op1(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
      int lat;
      ordy = 1'b1; a = ta; b = tb; cin = tc; iv = 1'b1;
      @(negedge clk);
      chk(tg({nm, " in_ready"}), 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      iv = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ov && lat < S + 4);
      chk(tg({nm, " latency"}), 64'(lat), 64'(S));
      chk(tg({nm, " sum"}), 64'(s), 64'(es));
      chk(tg({nm, " cout"}), 64'(co), 64'(ec));
      chk(tg({nm, " ovf"}), 64'(of), 64'(eo));
      @(posedge clk); #1;
    endtask

    initial begin
      int acc, n0, m, nf, nr;
      bit rdy;
      rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; cin = 1'b0;
      #1;
      chk(tg("reset out_valid"), 64'(ov), 64'(0));
      chk(tg("reset sum"), 64'(s), 64'(0));
      chk(tg("reset flags"), 64'({co, of}), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk(tg("idle in_ready"), 64'(in_ready), 64'(1));
      op1('1, W'(1), 1'b0, '0, 1'b1, 1'b0, "carry");
      op1('1, '0, 1'b1, '0, 1'b1, 1'b0, "carry cin");
      op1(MAXP, W'(1), 1'b0, MINN, 1'b0, 1'b1, "ovf pos");
      op1(MINN, MINN, 1'b0, '0, 1'b1, 1'b1, "ovf neg");

      n0 = out_cyc.size();
      ordy = 1'b1;
      for (int i = 0; i < 32; i++) begin
        a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom()); iv = 1'b1;
        @(negedge clk);
        chk(tg("stream in_ready"), 64'(in_ready), 64'(1));
        @(posedge clk); #1;
      end
      iv = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1;
      m = out_cyc.size();
      chk(tg("stream count"), 64'(m - n0), 64'(32));
      if (m >= 32) chk(tg("stream spacing"), 64'(out_cyc[m-1] - out_cyc[m-32]), 64'(31));

      n0 = out_cyc.size();
      ordy = 1'b0; acc = 0;
      a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom()); iv = 1'b1;
      repeat (2 * S + 4) begin
        @(negedge clk);
        rdy = in_ready;
        if (rdy) acc++;
        @(posedge clk); #1;
        if (rdy) begin
          a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
        end
      end
      iv = 1'b0;
      chk(tg("bp accepted"), 64'(acc), 64'(S));
      chk(tg("bp in_ready"), 64'(in_ready), 64'(0));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk(tg("bp hold valid"), 64'(ov), 64'(1));
        if (q.size() != 0) chk(tg("bp hold data"), 64'({of, co, s}), 64'(q[0]));
        @(posedge clk); #1;
      end
      nf = 0;
      while (q.size() != 0 && nf < 4 * S + 16) begin
        ordy = (nf % 2 == 0);
        @(posedge clk); #1;
        nf++;
      end
      ordy = 1'b1;
      chk(tg("bp drained"), 64'(q.size()), 64'(0));
      chk(tg("bp delivered"), 64'(out_cyc.size() - n0), 64'(S));

      ordy = 1'b0;
      nr = S < 3 ? S : 3;
      for (int i = 0; i < nr; i++) begin
        a = W'(i + 3); b = W'(i + 4); cin = 1'b0; iv = 1'b1;
        @(posedge clk); #1;
      end
      iv = 1'b0;
      repeat (S) @(posedge clk);
      #1;
      chk(tg("pre-reset valid"), 64'(ov), 64'(1));
      chk(tg("pre-reset sum"), 64'(s), 64'(7));
      n0 = out_cyc.size();
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk(tg("async reset valid"), 64'(ov), 64'(0));
      chk(tg("async reset sum"), 64'(s), 64'(0));
      chk(tg("async reset flags"), 64'({co, of}), 64'(0));
      @(negedge clk); rst_n = 1'b1; ordy = 1'b1;
      #1;
      chk(tg("post-reset in_ready"), 64'(in_ready), 64'(1));
      repeat (2 * S + 2) @(posedge clk);
      #1;
      chk(tg("flushed outputs"), 64'(out_cyc.size() - n0), 64'(0));
      chk(tg("flushed valid"), 64'(ov), 64'(0));
      op1(W'(5), W'(9), 1'b1, W'(15), 1'b0, 1'b0, "post reset");
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(done[0] && done[1] && done[2] && done[3]); i++) @(posedge clk);
    chk("all configs done", 64'(done[0] && done[1] && done[2] && done[3]), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple adder.
- Splits a WIDTH-bit add into STAGES carry-chained chunks, one chunk per register stage.
- Valid/ready handshakes on input and output, full backpressure, one operation per cycle throughput.
- Sits between streaming datapath producers and consumers; also reports carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- STAGES, 4, number of pipeline stages. Chunk width is CHUNK = WIDTH/STAGES.
- Constraints: STAGES >= 1, WIDTH % STAGES == 0. Elaboration fails otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  a, b and cin are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  unsigned carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst low, asynchronous):
  - All stage valid flags clear immediately.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 while rst is high and the pipe is empty.
  - Any in-flight operations are discarded, not completed.
- Input transfer occurs on a rising edge with in_valid && in_ready. Output transfer occurs on a rising edge with out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - valid_k;
  - result chunks 0..k, already summed;
  - carry out of chunk k;
  - carry into the MSB, kept in the stage that contains the MSB;
  - unsummed upper chunks k+1..STAGES-1 of a and b.
- Stage 0 sums chunk 0 of a and b with cin. Stage k>0 sums chunk k using the carry registered by stage k-1.
- Per-stage advance rule:
  - ready_k = !valid_k || ready_(k+1).
  - ready_STAGES = out_ready.
  - in_ready = ready_0. This is a combinational path from out_ready through the chain; no skid buffer.
- Stage k loads when ready_k is high. Its valid becomes the upstream valid (in_valid for stage 0). Bubbles collapse.
- Latency: an operation accepted at edge N shows out_valid=1 after edge N+STAGES-1 when never stalled. It is visible during the cycle following that edge.
- Throughput: one result per cycle with out_ready held high.
- Capacity: STAGES operations. With out_ready low, in_ready falls once all stages are valid.
- While out_valid && !out_ready, sum, cout and ovf hold stable.
- Results leave in acceptance order. None are dropped or duplicated.
- Arithmetic:
  - Full (WIDTH+1)-bit result; sum is the low WIDTH bits, cout is bit WIDTH.
  - ovf uses two's-complement interpretation of a and b.
  - For WIDTH=1, ovf = cin XOR cout.
- Data registers reset to 0. When valid is low, their contents are don't-care except that the output ports stay at their last value.
- STAGES=1: single registered adder, latency 1 cycle, same handshake rules.
- STAGES=WIDTH: one bit per stage, legal.

Test Plan (WIDTH=8, STAGES=4 unless noted):
- Reset: assert rst=0 mid-stream with 3 operations in flight -> out_valid=0 and sum/cout/ovf=0 without waiting for a clock edge. After release, in_ready=1 and none of the flushed results ever appear.
- Full carry ripple: a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid after edge N+3, sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Signed overflow: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Streaming: 32 back-to-back random operations, out_ready=1 -> 32 results on consecutive cycles, in order, each equal to the software model of a+b+cin.
- Backpressure: stream with out_ready=0 -> in_ready drops after exactly 4 acceptances, and outputs stay frozen on the first result. Then toggle out_ready 1,0,1,0 -> every result delivered exactly once, in order.
- Config sweep: repeat the carry and streaming checks for (WIDTH=8, STAGES=1) with latency 1, (WIDTH=8, STAGES=8), and (WIDTH=16, STAGES=2). Check a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1.
